alarm_sequencer: RTL
====================

Name: alarm_sequencer

Overview:
- Sequences the alarm/sound path of the alarm clock.
- Detects an alarm match against current time and day on each minute tick, then drives a ring / snooze / auto-timeout state machine.
- Generates the sound, display-blink and button-enable outputs consumed by the display and sound drivers.
- Sits beside the main time-keeping control unit; it only reads time and alarm registers and never writes them.

Parameters:
- SNOOZE_MIN, 9: minutes spent in SNOOZE before ringing again (1..15).
- RING_TIMEOUT_MIN, 5: minutes of continuous ringing before automatic shut-off (1..15).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (0..7).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Clr  in  1  reset, asynchronous, active-low.
- MinTick  in  1  one-cycle pulse per minute; time inputs are already updated in that cycle.
- HalfTick  in  1  one-cycle pulse every 0.5 s; blink timebase.
- cur_hour  in  5  current hour, 0..23.
- cur_min  in  6  current minute, 0..59.
- cur_day  in  3  current day, 0..6.
- alarm_hour  in  5  alarm hour, 0..23.
- alarm_min  in  6  alarm minute, 0..59.
- day_mask  in  7  bit d=1 means the alarm is active on day d.
- AlarmSet  in  1  level; alarm armed.
- Snooze  in  1  one-cycle debounced pulse.
- Stop  in  1  one-cycle debounced pulse.
- Mute  in  1  level; silences sound without changing state.
- sound  out  1  alarm tone enable.
- dblink  out  1  display blink phase.
- EN_SNZ  out  1  snooze button accepted this cycle.
- EN_STOP  out  1  stop button accepted this cycle.
- state  out  2  IDLE=00, RINGING=01, SNOOZE=10 (11 unused).
- snoozes_left  out  3  MAX_SNOOZE minus snoozes used.

Behaviour:
- Reset (Clr=0, asynchronous) clears all registers and outputs:
  - state=IDLE, ring_min=0, snz_min=0, snz_cnt=0, dblink=0, sound=0.
  - snoozes_left=MAX_SNOOZE.
  - Reset asserted mid-ring silences the alarm immediately.
- match = AlarmSet & MinTick & (cur_hour==alarm_hour) & (cur_min==alarm_min) & day_mask[cur_day]. It is combinational and sampled on the edge ending the MinTick cycle.
- Transition priority per edge, highest first:
  - (1) AlarmSet=0 or Stop: go to IDLE.
  - (2) Snooze.
  - (3) MinTick timing.
- IDLE:
  - On match, go to RINGING with ring_min=0 and snz_cnt=0.
  - Snooze and MinTick are otherwise ignored.
- RINGING:
  - Snooze with snz_cnt<MAX_SNOOZE: go to SNOOZE, snz_min=0, snz_cnt+1.
  - Snooze with snz_cnt==MAX_SNOOZE: ignored.
  - Each MinTick increments ring_min. When ring_min+1==RING_TIMEOUT_MIN, go to IDLE on that edge.
  - Snooze and a timeout MinTick in the same cycle: Snooze wins.
- SNOOZE:
  - Each MinTick increments snz_min. When snz_min+1==SNOOZE_MIN, go to RINGING with ring_min=0.
  - Snooze is ignored.
  - A match during SNOOZE or RINGING has no effect (no re-arm).
- Stop in the same minute as the match does not re-trigger, because match is only sampled on MinTick.
- All counters saturate and never wrap. Counter widths: ring_min and snz_min 4 bits, snz_cnt 3 bits.
- sound = (state==RINGING) & ~Mute. Combinational from the registered state, so Mute takes effect in the same cycle.
- dblink:
  - Registered.
  - Toggles on HalfTick while state!=IDLE.
  - Forced to 0 on the edge that enters IDLE.
- EN_SNZ = (state==RINGING) & (snz_cnt<MAX_SNOOZE).
- EN_STOP = (state!=IDLE).
- snoozes_left = MAX_SNOOZE - snz_cnt.
- Latency: match to sound is 1 cycle (the state register edge).

Test Plan:
- Armed, alarm=07:30, day_mask=0000010, cur_day=1. MinTick with time 07:30 -> state=01, sound=1 the next cycle; dblink toggles on each HalfTick.
- Same setup with cur_day=2 -> state stays 00 and sound stays 0.
- Ringing, Snooze pulse -> state=10, sound=0, snoozes_left=2. After 9 MinTicks -> state=01, sound=1. Repeat 3 snoozes -> EN_SNZ=0 and a 4th Snooze leaves state=01.
- Ringing with no input, 5 MinTicks -> state=00 and dblink=0 after the 5th edge. Snooze and the 5th MinTick in the same cycle -> state=10.
- Ringing, Mute=1 -> sound=0 in the same cycle while state stays 01. Stop and Snooze in the same cycle -> state=00.
- Snoozing, pull Clr low between edges -> sound=0, state=00, snoozes_left=3 immediately. AlarmSet dropped while ringing -> state=00 on the next edge.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/timeout sequencer: samples the alarm match on each minute tick and
// drives tone, blink and button-enable outputs. Read-only with respect to time/alarm registers.
module alarm_sequencer #(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 5,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       MinTick,
  input  logic       HalfTick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [2:0] cur_day,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic [6:0] day_mask,
  input  logic       AlarmSet,
  input  logic       Snooze,
  input  logic       Stop,
  input  logic       Mute,
  output logic       sound,
  output logic       dblink,
  output logic       EN_SNZ,
  output logic       EN_STOP,
  output logic [1:0] state,
  output logic [2:0] snoozes_left
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  localparam logic [3:0] SNZ_LIM  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIM = 4'(RING_TIMEOUT_MIN);
  localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZE);

  state_t     state_q, state_nxt;
  logic [3:0] ring_min, ring_nxt;
  logic [3:0] snz_min, snz_min_nxt;
  logic [2:0] snz_cnt, snz_cnt_nxt;
  logic       match, snz_ok;

  assign match  = AlarmSet & MinTick & (cur_hour == alarm_hour) &
                  (cur_min == alarm_min) & day_mask[cur_day];
  assign snz_ok = (snz_cnt < SNZ_MAX);

  always_comb begin
    state_nxt   = state_q;
    ring_nxt    = ring_min;
    snz_min_nxt = snz_min;
    snz_cnt_nxt = snz_cnt;
    if (!AlarmSet || Stop) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_nxt   = RINGING;
            ring_nxt    = '0;
            snz_cnt_nxt = '0;
          end
        end
        RINGING: begin
          // A rejected snooze (limit reached) lets the minute tick proceed as usual.
          if (Snooze && snz_ok) begin
            state_nxt   = SNOOZE;
            snz_min_nxt = '0;
            snz_cnt_nxt = (snz_cnt == 3'h7) ? snz_cnt : snz_cnt + 3'd1;
          end else if (MinTick) begin
            ring_nxt = (ring_min == 4'hF) ? ring_min : ring_min + 4'd1;
            if (ring_min + 4'd1 == RING_LIM) state_nxt = IDLE;
          end
        end
        SNOOZE: begin
          if (MinTick) begin
            snz_min_nxt = (snz_min == 4'hF) ? snz_min : snz_min + 4'd1;
            if (snz_min + 4'd1 == SNZ_LIM) begin
              state_nxt = RINGING;
              ring_nxt  = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q  <= IDLE;
      ring_min <= '0;
      snz_min  <= '0;
      snz_cnt  <= '0;
      dblink   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      ring_min <= ring_nxt;
      snz_min  <= snz_min_nxt;
      snz_cnt  <= snz_cnt_nxt;
      if (state_nxt == IDLE)                  dblink <= 1'b0;
      else if (HalfTick && state_q != IDLE)   dblink <= ~dblink;
    end
  end

  // Tone follows the registered state so reset and Mute act without waiting for an edge.
  assign sound        = (state_q == RINGING) & ~Mute;
  assign EN_SNZ       = (state_q == RINGING) & snz_ok;
  assign EN_STOP      = (state_q != IDLE);
  assign state        = state_q;
  assign snoozes_left = SNZ_MAX - snz_cnt;

endmodule
